// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between fetch and the Alpha/Beta decoders.
// Accepts up to two instructions per cycle and presents the two oldest entries.
module inst_fetch_queue #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid_a,
  input  logic [31:0]      in_inst_a,
  input  logic [31:0]      in_pc_a,
  input  logic             in_valid_b,
  input  logic [31:0]      in_inst_b,
  input  logic [31:0]      in_pc_b,
  output logic             full,
  output logic             out_valid_a,
  output logic [31:0]      out_inst_a,
  output logic [31:0]      out_pc_a,
  output logic             out_valid_b,
  output logic [31:0]      out_inst_b,
  output logic [31:0]      out_pc_b,
  input  logic [1:0]       issue_count,
  output logic [PTR_W:0]   count
);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [1:0]       issue_eff;
  logic [1:0]       push_n;
  logic [PTR_W:0]   pop_n;
  logic             push_ok;
  logic [63:0]      entry_a;
  logic [63:0]      entry_b;

  // full looks only at pre-update occupancy, so it stays conservative under a same-cycle pop
  assign full    = count > (PTR_W+1)'(DEPTH - 2);
  assign push_ok = !full && !flush && !rst;

  always_comb begin
    issue_eff = (issue_count == 2'd3) ? 2'd2 : issue_count;
    pop_n     = ((PTR_W+1)'(issue_eff) > count) ? count : (PTR_W+1)'(issue_eff);
    push_n    = '0;
    if (push_ok) begin
      push_n = {1'b0, in_valid_a} + {1'b0, in_valid_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + (PTR_W+1)'(push_n) - pop_n;
    end
  end

  // B lands at tail when A is absent, keeping the valid slots compacted
  always_ff @(posedge clk) begin
    if (push_ok) begin
      if (in_valid_a) begin
        mem[tail] <= {in_inst_a, in_pc_a};
      end
      if (in_valid_b) begin
        mem[tail + PTR_W'(in_valid_a)] <= {in_inst_b, in_pc_b};
      end
    end
  end

  assign entry_a     = mem[head];
  assign entry_b     = mem[head + PTR_W'(1)];
  assign out_valid_a = count >= (PTR_W+1)'(1);
  assign out_valid_b = count >= (PTR_W+1)'(2);
  assign out_inst_a  = out_valid_a ? entry_a[63:32] : '0;
  assign out_pc_a    = out_valid_a ? entry_a[31:0]  : '0;
  assign out_inst_b  = out_valid_b ? entry_b[63:32] : '0;
  assign out_pc_b    = out_valid_b ? entry_b[31:0]  : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int VW = (PTR_W + 1) + 1 + 2 * 65;

  logic clk = 1'b0;
  logic rst, flush;
  logic in_valid_a, in_valid_b;
  logic [31:0] in_inst_a, in_pc_a, in_inst_b, in_pc_b;
  logic [1:0] issue_count;
  logic full, out_valid_a, out_valid_b;
  logic [31:0] out_inst_a, out_pc_a, out_inst_b, out_pc_b;
  logic [PTR_W:0] count;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [VW-1:0] obs;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_a(in_valid_a), .in_inst_a(in_inst_a), .in_pc_a(in_pc_a),
    .in_valid_b(in_valid_b), .in_inst_b(in_inst_b), .in_pc_b(in_pc_b),
    .full(full),
    .out_valid_a(out_valid_a), .out_inst_a(out_inst_a), .out_pc_a(out_pc_a),
    .out_valid_b(out_valid_b), .out_inst_b(out_inst_b), .out_pc_b(out_pc_b),
    .issue_count(issue_count), .count(count)
  );

  assign obs = {count, full, out_valid_a, out_inst_a, out_pc_a, out_valid_b, out_inst_b, out_pc_b};

  function automatic logic [VW-1:0] exp_vec();
    int n;
    logic [63:0] ea, eb;
    n  = q.size();
    ea = (n >= 1) ? q[0] : 64'h0;
    eb = (n >= 2) ? q[1] : 64'h0;
    return {(PTR_W+1)'(n), ((DEPTH - n) < 2), (n >= 1), ea, (n >= 2), eb};
  endfunction

  task automatic model_update();
    int n, p;
    bit f;
    n = q.size();
    if (rst || flush) begin
      q.delete();
    end else begin
      p = (issue_count == 2'd3) ? 2 : int'(issue_count);
      if (p > n) p = n;
      f = (DEPTH - n) < 2;
      repeat (p) void'(q.pop_front());
      if (!f) begin
        if (in_valid_a) q.push_back({in_inst_a, in_pc_a});
        if (in_valid_b) q.push_back({in_inst_b, in_pc_b});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic va, input logic [31:0] ia, input logic [31:0] pa,
                       input logic vb, input logic [31:0] ib, input logic [31:0] pb,
                       input logic [1:0] ic);
    in_valid_a = va; in_inst_a = ia; in_pc_a = pa;
    in_valid_b = vb; in_inst_b = ib; in_pc_b = pb;
    issue_count = ic;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== exp_vec() || obs !== '0) begin
      errors++; $display("FAIL reset: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_fill();
    drive(1'b1, 32'h24010001, 32'hBFC00000, 1'b1, 32'h24020002, 32'hBFC00004, 2'd0);
    step();
    checks++;
    if (count !== 4'd2 || out_inst_a !== 32'h24010001 || out_pc_b !== 32'hBFC00004 ||
        obs !== exp_vec()) begin
      errors++; $display("FAIL fill_first: got %h expected %h", obs, exp_vec());
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'h24000000 + i * 2, 32'hBFC00000 + i * 8,
            1'b1, 32'h24000001 + i * 2, 32'hBFC00004 + i * 8, 2'd0);
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL fill_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL fill_full: got count=%0d full=%b expected count=8 full=1", count, full);
    end
  endtask

  task automatic test_full_drop();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd1);
    step();
    drive(1'b1, 32'hDEAD0001, 32'h1000, 1'b1, 32'hDEAD0002, 32'h1004, 2'd0);
    step();
    checks++;
    if (count !== 4'd7 || full !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL full_drop: got %h expected %h", obs, exp_vec());
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd2);
    step();
    checks++;
    if (count !== 4'd5 || full !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL full_drain: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] nxt, pc;
    int pops;
    idle(); rst = 1'b1; step(); rst = 1'b0;
    drive(1'b1, 32'hA0000000, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    step();
    nxt = 32'h0; pc = 32'h4;
    for (int i = 0; i < 6; i++) begin
      pops = (q.size() < 2) ? q.size() : 2;
      checks++;
      if ((out_valid_a && out_pc_a !== nxt) || (out_valid_b && out_pc_b !== nxt + 32'h4)) begin
        errors++; $display("FAIL wrap_order_%0d: got pc_a=%h pc_b=%h expected %h %h", i, out_pc_a, out_pc_b, nxt, nxt + 32'h4);
      end
      nxt += 32'(pops * 4);
      drive(1'b1, 32'hA0000000 | pc, pc, 1'b1, 32'hA0000000 | (pc + 32'h4), pc + 32'h4, 2'd2);
      pc += 32'h8;
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wrap_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_clamp();
    idle(); flush = 1'b1; step(); flush = 1'b0;
    drive(1'b1, 32'h11111111, 32'h200, 1'b0, 32'h0, 32'h0, 2'd0);
    step();
    drive(1'b1, 32'h22222222, 32'h204, 1'b1, 32'h33333333, 32'h208, 2'd2);
    step();
    checks++;
    if (count !== 4'd2 || out_pc_a !== 32'h204 || out_inst_a !== 32'h22222222 || obs !== exp_vec()) begin
      errors++; $display("FAIL clamp: got %h expected %h", obs, exp_vec());
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd3);
    step();
    checks++;
    if (count !== 4'd0 || obs !== exp_vec()) begin
      errors++; $display("FAIL issue3: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_b_only();
    drive(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h100, 2'd0);
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++; $display("FAIL no_bypass: got valid_a=%b expected 0", out_valid_a);
    end
    step();
    checks++;
    if (out_valid_a !== 1'b1 || out_pc_a !== 32'h100 || out_valid_b !== 1'b0 ||
        out_inst_b !== 32'h0 || out_pc_b !== 32'h0 || obs !== exp_vec()) begin
      errors++; $display("FAIL b_only: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + i, 32'h300 + i * 8, 1'b1, 32'h6000 + i, 32'h304 + i * 8, 2'd0);
      step();
    end
    idle();
    drive(1'b1, 32'hBAD0, 32'h900, 1'b1, 32'hBAD1, 32'h904, 2'd2);
    checks++;
    if (count !== 4'd7) begin
      errors++; $display("FAIL flush_setup: got count=%0d expected 7", count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd2);
    step();
    drive(1'b1, 32'hBAD0, 32'h900, 1'b1, 32'hBAD1, 32'h904, 2'd2);
    flush = 1'b1;
    step();
    idle();
    checks++;
    if (count !== '0 || out_valid_a !== 1'b0 || full !== 1'b0 || obs !== exp_vec()) begin
      errors++; $display("FAIL flush: got %h expected %h", obs, exp_vec());
    end
    step();
    checks++;
    if (out_valid_a !== 1'b0 || out_pc_a !== 32'h0 || obs !== exp_vec()) begin
      errors++; $display("FAIL flush_ghost: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h7001, 32'h700, 1'b1, 32'h7002, 32'h704, 2'd0);
    step(); step();
    drive(1'b1, 32'h7003, 32'h708, 1'b1, 32'h7004, 32'h70C, 2'd1);
    rst = 1'b1; flush = 1'b1;
    step();
    idle();
    checks++;
    if (obs !== '0 || obs !== exp_vec()) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
            ($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_drop();
    test_wrap();
    test_clamp();
    test_b_only();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
